// File: rtl/instr_encoder_loader_pkg.sv
// Shared types and RV32I encoding constants for the IMEM loader.
// The opcode/funct constants are the same ones the control decoder matches on.
package instr_encoder_loader_pkg;

   // Symbolic micro-op kinds. Codes 12..15 are left unused, so they reach the loader as illegal ops.
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_ADDI = 4'd2,
      OP_SLL  = 4'd3,
      OP_SLLI = 4'd4,
      OP_SRL  = 4'd5,
      OP_SRLI = 4'd6,
      OP_SRA  = 4'd7,
      OP_SRAI = 4'd8,
      OP_LW   = 4'd9,
      OP_SW   = 4'd10,
      OP_BEQ  = 4'd11
   } enc_op_type;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_RANGE    = 2'd1,
      ERR_ILLEGAL  = 2'd2,
      ERR_OVERFLOW = 2'd3
   } err_type;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_type;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_LW_SW   = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // True when the 32-bit two's-complement value lies in [lo, hi].
   function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
      return ($signed(v) >= lo) && ($signed(v) <= hi);
   endfunction

endpackage

// File: rtl/instr_encoder_loader_rv_field_packer.sv
// Combinational RV32I packer: one micro-op in, one instruction word plus legality flags out.
module rv_field_packer
   import instr_encoder_loader_pkg::*;
(
   input  enc_op_type  enc_op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        range_ok,
   output logic        legal
);

   logic imm12_ok;
   logic shamt_ok;
   logic branch_ok;

   // Immediate range checks for the three immediate flavours.
   always_comb begin
      imm12_ok  = in_range(imm, -2048, 2047);
      shamt_ok  = (imm[31:5] == 27'd0);
      branch_ok = in_range(imm, -4096, 4094) && !imm[0];
   end

   // Field packing; an unknown op code yields a zero word and legal=0.
   always_comb begin
      word     = '0;
      range_ok = 1'b1;
      legal    = 1'b1;
      case (enc_op)
         OP_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
         OP_SUB:  word = {F7_ALT,  rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
         OP_SLL:  word = {F7_BASE, rs2, rs1, F3_SLL,     rd, OPC_OP};
         OP_SRL:  word = {F7_BASE, rs2, rs1, F3_SRL_SRA, rd, OPC_OP};
         OP_SRA:  word = {F7_ALT,  rs2, rs1, F3_SRL_SRA, rd, OPC_OP};
         OP_ADDI: begin
            word     = {imm[11:0], rs1, F3_ADD_SUB, rd, OPC_OP_IMM};
            range_ok = imm12_ok;
         end
         OP_SLLI: begin
            word     = {F7_BASE, imm[4:0], rs1, F3_SLL, rd, OPC_OP_IMM};
            range_ok = shamt_ok;
         end
         OP_SRLI: begin
            word     = {F7_BASE, imm[4:0], rs1, F3_SRL_SRA, rd, OPC_OP_IMM};
            range_ok = shamt_ok;
         end
         OP_SRAI: begin
            word     = {F7_ALT, imm[4:0], rs1, F3_SRL_SRA, rd, OPC_OP_IMM};
            range_ok = shamt_ok;
         end
         OP_LW: begin
            word     = {imm[11:0], rs1, F3_LW_SW, rd, OPC_LOAD};
            range_ok = imm12_ok;
         end
         OP_SW: begin
            word     = {imm[11:5], rs2, rs1, F3_LW_SW, imm[4:0], OPC_STORE};
            range_ok = imm12_ok;
         end
         OP_BEQ: begin
            word     = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
            range_ok = branch_ok;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// IMEM loader: accepts micro-ops, encodes them to RV32I and writes one word per cycle.
// A transferred op becomes a registered write strobe in the following cycle.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int                    IMEM_DEPTH = 256,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          op_valid,
   output logic                          op_ready,
   input  logic                          op_last,
   input  enc_op_type                    enc_op,
   input  logic [4:0]                    rd,
   input  logic [4:0]                    rs1,
   input  logic [4:0]                    rs2,
   input  logic [31:0]                   imm,
   output logic                          imem_we,
   output logic [ADDR_WIDTH-1:0]         imem_addr,
   output logic [31:0]                   imem_wdata,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output err_type                       err_code,
   output logic [$clog2(IMEM_DEPTH):0]   word_count
);

   localparam int CW = $clog2(IMEM_DEPTH) + 1;

   state_type             state_q, state_d;
   logic [CW-1:0]         word_count_q, word_count_d;
   logic                  last_seen_q, last_seen_d;
   err_type               err_q, err_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;

   logic [31:0] enc_word;
   logic        enc_range_ok;
   logic        enc_legal;
   logic [CW:0] occupancy;
   logic        room;
   logic        transfer;

   rv_field_packer u_packer (
      .enc_op   (enc_op),
      .rd       (rd),
      .rs1      (rs1),
      .rs2      (rs2),
      .imm      (imm),
      .word     (enc_word),
      .range_ok (enc_range_ok),
      .legal    (enc_legal)
   );

   // Words committed so far, counting the one still sitting in the output register.
   always_comb begin
      occupancy = {1'b0, word_count_q} + (CW + 1)'(imem_we_q);
      room      = occupancy < (CW + 1)'(IMEM_DEPTH);
      op_ready  = (state_q == ST_RUN) && !last_seen_q && room;
      transfer  = op_valid && op_ready;
   end

   // Next-state, write-stage and error-latch logic.
   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q + CW'(imem_we_q);
      last_seen_d  = last_seen_q;
      err_d        = err_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      case (state_q)
         ST_RUN: begin
            if (transfer && !enc_legal) begin
               state_d = ST_ERROR;
               err_d   = ERR_ILLEGAL;
            end else if (transfer && !enc_range_ok) begin
               state_d = ST_ERROR;
               err_d   = ERR_RANGE;
            end else if (transfer) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = BASE_ADDR + ADDR_WIDTH'({occupancy, 2'b00});
               imem_wdata_d = enc_word;
               last_seen_d  = op_last;
            end else if (last_seen_q && imem_we_q) begin
               // The final word is being written this cycle.
               state_d = ST_DONE;
            end else if (!last_seen_q && op_valid && !room) begin
               state_d = ST_ERROR;
               err_d   = ERR_OVERFLOW;
            end
         end
         default: begin
            if (start) begin
               state_d      = ST_RUN;
               word_count_d = '0;
               last_seen_d  = 1'b0;
               err_d        = ERR_NONE;
            end
         end
      endcase
   end

   // State and output registers; reset drops any pending write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         word_count_q <= '0;
         last_seen_q  <= 1'b0;
         err_q        <= ERR_NONE;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         last_seen_q  <= last_seen_d;
         err_q        <= err_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERROR);
   assign err_code   = err_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: stimulus pushes expected writes into a queue, a monitor pops and compares.
module tb_instr_encoder_loader;
   import instr_encoder_loader_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          op_valid = 1'b0;
   logic          op_last = 1'b0;
   enc_op_type    enc_op = OP_ADD;
   logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
   logic [31:0]   imm = '0;
   logic          op_ready, imem_we, busy, done, error;
   logic [31:0]   imem_addr, imem_wdata;
   err_type       err_code;
   logic [CW-1:0] word_count;

   instr_encoder_loader #(.IMEM_DEPTH(DEPTH), .ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_last    (op_last),
      .enc_op     (enc_op),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .imm        (imm),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   we_cycle_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cycle = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every write strobe must match the oldest queued expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && imem_we) begin
         we_cycle_q.push_back(cycle);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                     imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            $display("[TB] write @0x%08h = 0x%08h (expected 0x%08h @0x%08h)",
                     imem_addr, imem_wdata, e.data, e.addr);
            check("wr_addr", imem_addr, e.addr);
            check("wr_data", imem_wdata, e.data);
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Offer one micro-op; queue its expected write if one should follow.
   task automatic send(input enc_op_type op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im, input logic last,
                       input logic exp_write, input logic [31:0] exp_addr,
                       input logic [31:0] exp_word, output logic accepted);
      exp_t e;
      enc_op   = op;
      rd       = d;
      rs1      = s1;
      rs2      = s2;
      imm      = im;
      op_last  = last;
      op_valid = 1'b1;
      accepted = 1'b0;
      for (int n = 0; n < 10 && !accepted; n++) begin
         @(negedge clk);
         if (op_ready) begin
            accepted = 1'b1;
            if (exp_write) begin
               e.addr = exp_addr;
               e.data = exp_word;
               exp_q.push_back(e);
            end
         end
         @(posedge clk);
         #1;
      end
      op_valid = 1'b0;
      op_last  = 1'b0;
   endtask

   // Wait (bounded) for the session to end and check its status outputs.
   task automatic finish_session(input string name, input logic exp_done, input logic exp_err,
                                 input err_type exp_code, input int exp_count);
      int n;
      n = 0;
      @(negedge clk);
      while (!(done || error) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!(done || error)) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got done=0 error=0 after 20 cycles, expected session end", name);
      end
      $display("[TB] %s: done=%0d error=%0d err_code=%0d word_count=%0d",
               name, done, error, err_code, word_count);
      check({name, "_done"}, 32'(done), 32'(exp_done));
      check({name, "_error"}, 32'(error), 32'(exp_err));
      check({name, "_err_code"}, 32'(err_code), 32'(exp_code));
      check({name, "_word_count"}, 32'(word_count), 32'(exp_count));
      check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic acc;
      int   base_idx;

      // Reset state.
      @(negedge clk);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_imem_addr", imem_addr, 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_err_code", 32'(err_code), 32'(ERR_NONE));
      check("rst_word_count", 32'(word_count), 32'd0);
      check("rst_op_ready", 32'(op_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ADDI x1,x0,5 ; ADD x3,x1,x2 (last).
      do_start();
      send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h0, 32'h00500093, acc);
      check("s1_acc0", 32'(acc), 32'd1);
      send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h4, 32'h002081B3, acc);
      check("s1_acc1", 32'(acc), 32'd1);
      finish_session("s1", 1'b1, 1'b0, ERR_NONE, 2);
      check("s1_ready_in_done", 32'(op_ready), 32'd0);

      // SUB ; SRAI back-to-back, no bubble between writes.
      base_idx = we_cycle_q.size();
      do_start();
      send(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h0, 32'h402081B3, acc);
      send(OP_SRAI, 5'd5, 5'd5, 5'd0, 32'd3, 1'b1, 1'b1, 32'h4, 32'h4032D293, acc);
      finish_session("s2", 1'b1, 1'b0, ERR_NONE, 2);
      if (we_cycle_q.size() >= base_idx + 2)
         check("s2_no_bubble", 32'(we_cycle_q[base_idx+1] - we_cycle_q[base_idx]), 32'd1);
      else
         check("s2_write_count", 32'(we_cycle_q.size() - base_idx), 32'd2);

      // LW ; SW ; BEQ.
      do_start();
      send(OP_LW, 5'd6, 5'd2, 5'd0, 32'd8, 1'b0, 1'b1, 32'h0, 32'h00812303, acc);
      send(OP_SW, 5'd0, 5'd2, 5'd6, 32'd8, 1'b0, 1'b1, 32'h4, 32'h00612423, acc);
      send(OP_BEQ, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 1'b1, 32'h8, 32'hFE208CE3, acc);
      finish_session("s3", 1'b1, 1'b0, ERR_NONE, 3);

      // SLL ; SRA ; SLLI with shamt 31.
      do_start();
      send(OP_SLL, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0, 1'b1, 32'h0, 32'h009413B3, acc);
      send(OP_SRA, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0, 1'b1, 32'h4, 32'h409453B3, acc);
      send(OP_SLLI, 5'd1, 5'd2, 5'd0, 32'd31, 1'b1, 1'b1, 32'h8, 32'h01F11093, acc);
      finish_session("s4", 1'b1, 1'b0, ERR_NONE, 3);

      // Good word then ADDI imm=2048: pending word still written, then ERR_RANGE.
      do_start();
      send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h0, 32'h00500093, acc);
      send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b0, 32'h0, 32'h0, acc);
      finish_session("s5", 1'b0, 1'b1, ERR_RANGE, 1);
      check("s5_ready_in_error", 32'(op_ready), 32'd0);

      // BEQ with odd offset.
      do_start();
      send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1, 1'b0, 32'h0, 32'h0, acc);
      finish_session("s6", 1'b0, 1'b1, ERR_RANGE, 0);

      // SLLI shamt 32 is out of range.
      do_start();
      send(OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32, 1'b1, 1'b0, 32'h0, 32'h0, acc);
      finish_session("s7", 1'b0, 1'b1, ERR_RANGE, 0);

      // Unknown op code.
      do_start();
      send(enc_op_type'(4'd13), 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 1'b0, 32'h0, 32'h0, acc);
      finish_session("s8", 1'b0, 1'b1, ERR_ILLEGAL, 0);

      // Five ops without op_last into a 4-word memory.
      do_start();
      for (int i = 0; i < 4; i++) begin
         send(OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0, 1'b1, 32'(4 * i), 32'h00108093, acc);
         check("s9_acc", 32'(acc), 32'd1);
      end
      send(OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0, 1'b0, 32'h0, 32'h0, acc);
      check("s9_fifth_refused", 32'(acc), 32'd0);
      finish_session("s9", 1'b0, 1'b1, ERR_OVERFLOW, 4);

      // op_last on exactly the 4th word.
      do_start();
      for (int i = 0; i < 4; i++)
         send(OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd1, (i == 3), 1'b1, 32'(4 * i), 32'h00108093, acc);
      finish_session("s10", 1'b1, 1'b0, ERR_NONE, 4);

      // Reset in the cycle after a transfer: the pending write is dropped.
      do_start();
      send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h0, 32'h00500093, acc);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("rst2_imem_we", 32'(imem_we), 32'd0);
      check("rst2_imem_wdata", imem_wdata, 32'd0);
      check("rst2_busy", 32'(busy), 32'd0);
      check("rst2_word_count", 32'(word_count), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_start();
      send(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd7, 1'b1, 1'b1, 32'h0, 32'h00700113, acc);
      finish_session("s11", 1'b1, 1'b0, ERR_NONE, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
